// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: word/register aliases plus the MEM-stage enums.
// Pure declarations, no logic.
// Imported by every pipeline stage that needs these widths or encodings.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  // Memory operation carried down the pipe from decode; encoding 7 decodes as NONE.
  typedef enum logic [2:0] {
    MOP_NONE = 3'd0,
    MOP_LDW  = 3'd1,
    MOP_LDB  = 3'd2,
    MOP_STW  = 3'd3,
    MOP_STB  = 3'd4,
    MOP_LDI  = 3'd5,
    MOP_STI  = 3'd6
  } lc3b_mem_op;

  // Writeback source select; 3 aliases the ALU result.
  typedef enum logic [1:0] {
    RFM_ALU  = 2'd0,
    RFM_MEM  = 2'd1,
    RFM_PC   = 2'd2,
    RFM_ALU2 = 2'd3
  } lc3b_regfilemux_sel;

  // IDLE services direct accesses and the pointer fetch of LDI/STI.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IND_GAP  = 2'd1,
    IND_DATA = 2'd2
  } mem_stage_state_t;

  localparam lc3b_word WORD_ADDR_MASK = 16'hFFFE;

  // Map a raw 3-bit op field onto the enum, folding the unused code into NONE.
  function automatic lc3b_mem_op decode_mem_op(input logic [2:0] raw);
    case (raw)
      3'd1:    decode_mem_op = MOP_LDW;
      3'd2:    decode_mem_op = MOP_LDB;
      3'd3:    decode_mem_op = MOP_STW;
      3'd4:    decode_mem_op = MOP_STB;
      3'd5:    decode_mem_op = MOP_LDI;
      3'd6:    decode_mem_op = MOP_STI;
      default: decode_mem_op = MOP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane alignment for loads and stores: sign-extends LDB data, replicates STB data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows the inputs of the enclosing stage.
module mem_byte_align
  import lc3b_types::*;
(
  input  logic       i_addr_lsb,
  input  lc3b_mem_op i_op,
  input  lc3b_word   i_mem_rdata,
  input  lc3b_word   i_store_data,
  output lc3b_word   o_load_data,
  output lc3b_word   o_wdata,
  output logic [1:0] o_byte_enable
);

  logic [7:0] w_lane_byte;

  assign w_lane_byte = i_addr_lsb ? i_mem_rdata[15:8] : i_mem_rdata[7:0];

  // Lane select and data formatting per operation; word ops pass through untouched.
  always_comb begin
    o_load_data   = i_mem_rdata;
    o_wdata       = i_store_data;
    o_byte_enable = 2'b00;
    case (i_op)
      MOP_LDB: o_load_data = {{8{w_lane_byte[7]}}, w_lane_byte};
      MOP_STB: begin
        o_wdata       = {i_store_data[7:0], i_store_data[7:0]};
        o_byte_enable = i_addr_lsb ? 2'b10 : 2'b01;
      end
      MOP_STW, MOP_STI: o_byte_enable = 2'b11;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: drives the data-memory handshake and selects the writeback value.
// Latency: zero added cycles for non-memory ops; memory ops finish in the mem_resp cycle.
// Backpressure: stall_out holds upstream while memory is busy; MEM/WB sees a bubble.
// Optional MEM_STAGE_PERF_EN adds a saturating 32-bit stall_count output.
module mem_stage
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [2:0]  mem_op_in,
  input  logic [2:0]  dest_in,
  input  logic [15:0] alu_out_in,
  input  logic [15:0] store_data_in,
  input  logic [15:0] pc_in,
  input  logic [1:0]  regfilemux_sel_in,
  input  logic        load_regfile_in,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [2:0]  dest_out,
  output logic [15:0] regfilemux_out,
  output logic        load_regfile_out,
  output logic        stall_out
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);

  mem_stage_state_t r_state, w_next;
  lc3b_word         r_ptr_q;

  lc3b_mem_op w_op;
  logic       w_active, w_indirect, w_byte_op;
  logic       w_read, w_write, w_stall, w_done, w_ptr_load;
  lc3b_word   w_addr, w_load_data, w_wdata, w_rfm;
  logic [1:0] w_be;

  assign w_op       = decode_mem_op(mem_op_in);
  assign w_active   = valid_in && (w_op != MOP_NONE);
  assign w_indirect = (w_op == MOP_LDI) || (w_op == MOP_STI);
  assign w_byte_op  = (w_op == MOP_LDB) || (w_op == MOP_STB);

  mem_byte_align u_align (
    .i_addr_lsb    (alu_out_in[0]),
    .i_op          (w_op),
    .i_mem_rdata   (mem_rdata),
    .i_store_data  (store_data_in),
    .o_load_data   (w_load_data),
    .o_wdata       (w_wdata),
    .o_byte_enable (w_be)
  );

  // Next state and request generation; mem_resp only matters while a request is up.
  always_comb begin
    w_next     = r_state;
    w_read     = 1'b0;
    w_write    = 1'b0;
    w_addr     = 16'h0000;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    w_ptr_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_active) begin
          w_addr  = w_byte_op ? alu_out_in : (alu_out_in & WORD_ADDR_MASK);
          w_write = (w_op == MOP_STW) || (w_op == MOP_STB);
          w_read  = !w_write;
          if (w_indirect) begin
            // Pointer fetch: never completes the instruction here.
            w_stall = 1'b1;
            if (mem_resp) begin
              w_ptr_load = 1'b1;
              w_next     = IND_GAP;
            end
          end else begin
            w_done  = mem_resp;
            w_stall = !mem_resp;
          end
        end
      end
      IND_GAP: begin
        // One request-free cycle so memory sees two distinct accesses.
        w_stall = 1'b1;
        w_next  = IND_DATA;
      end
      IND_DATA: begin
        w_addr  = r_ptr_q & WORD_ADDR_MASK;
        w_read  = (w_op == MOP_LDI);
        w_write = (w_op == MOP_STI);
        w_stall = !mem_resp;
        if (mem_resp) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Writeback source select.
  always_comb begin
    case (lc3b_regfilemux_sel'(regfilemux_sel_in))
      RFM_MEM: w_rfm = w_load_data;
      RFM_PC:  w_rfm = pc_in;
      default: w_rfm = alu_out_in;
    endcase
  end

  // All outputs forced low while reset is held; byte enables only qualify writes.
  assign mem_address      = rst ? 16'h0000 : w_addr;
  assign mem_wdata        = rst ? 16'h0000 : w_wdata;
  assign mem_read         = !rst && w_read;
  assign mem_write        = !rst && w_write;
  assign mem_byte_enable  = (rst || !w_write) ? 2'b00 : w_be;
  assign dest_out         = rst ? 3'd0 : dest_in;
  assign regfilemux_out   = rst ? 16'h0000 : w_rfm;
  assign load_regfile_out = !rst && valid_in && load_regfile_in && (!w_active || w_done);
  assign stall_out        = !rst && w_stall;

  // State register and indirect pointer capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr_q <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_ptr_load) r_ptr_q <= mem_rdata;
    end
  end

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] r_stall_count;
  assign stall_count = r_stall_count;

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) r_stall_count <= 32'd0;
    else if (stall_out && (r_stall_count != 32'hFFFF_FFFF)) r_stall_count <= r_stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
// Inputs change 1ns after posedge; outputs are checked 1ns later, well before the next edge.
// Build with MEM_STAGE_PERF_EN to also check the stall counter.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  mem_op_in;
  logic [2:0]  dest_in;
  logic [15:0] alu_out_in;
  logic [15:0] store_data_in;
  logic [15:0] pc_in;
  logic [1:0]  regfilemux_sel_in;
  logic        load_regfile_in;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [2:0]  dest_out;
  logic [15:0] regfilemux_out;
  logic        load_regfile_out;
  logic        stall_out;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .valid_in          (valid_in),
    .mem_op_in         (mem_op_in),
    .dest_in           (dest_in),
    .alu_out_in        (alu_out_in),
    .store_data_in     (store_data_in),
    .pc_in             (pc_in),
    .regfilemux_sel_in (regfilemux_sel_in),
    .load_regfile_in   (load_regfile_in),
    .mem_rdata         (mem_rdata),
    .mem_resp          (mem_resp),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byte_enable   (mem_byte_enable),
    .dest_out          (dest_out),
    .regfilemux_out    (regfilemux_out),
    .load_regfile_out  (load_regfile_out),
    .stall_out         (stall_out)
`ifdef MEM_STAGE_PERF_EN
    ,
    .stall_count       (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and leave time for inputs to be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] alu,
                       input logic [15:0] sd, input logic [1:0] sel, input logic ld);
    valid_in          = v;
    mem_op_in         = op;
    alu_out_in        = alu;
    store_data_in     = sd;
    regfilemux_sel_in = sel;
    load_regfile_in   = ld;
  endtask

  initial begin
    rst = 1'b1; pc_in = 16'h0000; dest_in = 3'd5;
    mem_rdata = 16'h0000; mem_resp = 1'b0;
    drive(1'b1, 3'd1, 16'h3001, 16'hFFFF, 2'd1, 1'b1);

    // Reset: every output low even with a live load presented.
    step(); step(); settle();
    chk("rst_read",  {31'd0, mem_read}, 32'd0);
    chk("rst_addr",  {16'd0, mem_address}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_lrf",   {31'd0, load_regfile_out}, 32'd0);
    chk("rst_dest",  {29'd0, dest_out}, 32'd0);
`ifdef MEM_STAGE_PERF_EN
    chk("rst_cnt", stall_count, 32'd0);
`endif

    // LDW, response in third cycle.
    rst = 1'b0; dest_in = 3'd3; mem_rdata = 16'hBEEF; settle();
    chk("ldw_addr", {16'd0, mem_address}, 32'h3000);
    chk("ldw_rd",   {31'd0, mem_read}, 32'd1);
    chk("ldw_st1",  {31'd0, stall_out}, 32'd1);
    chk("ldw_lrf1", {31'd0, load_regfile_out}, 32'd0);
    step(); settle();
    chk("ldw_st2",  {31'd0, stall_out}, 32'd1);
    chk("ldw_lrf2", {31'd0, load_regfile_out}, 32'd0);
    step(); mem_resp = 1'b1; settle();
    chk("ldw_st3",  {31'd0, stall_out}, 32'd0);
    chk("ldw_lrf3", {31'd0, load_regfile_out}, 32'd1);
    chk("ldw_rfm",  {16'd0, regfilemux_out}, 32'hBEEF);
    chk("ldw_dest", {29'd0, dest_out}, 32'd3);

    // LDB high lane, immediate response: 0x80 sign-extends.
    step(); drive(1'b1, 3'd2, 16'h4003, 16'h0000, 2'd1, 1'b1);
    mem_rdata = 16'h80FF; mem_resp = 1'b1; settle();
    chk("ldb_addr",  {16'd0, mem_address}, 32'h4003);
    chk("ldb_rfm",   {16'd0, regfilemux_out}, 32'hFF80);
    chk("ldb_stall", {31'd0, stall_out}, 32'd0);
    chk("ldb_lrf",   {31'd0, load_regfile_out}, 32'd1);

    // STB lane 0.
    step(); drive(1'b1, 3'd4, 16'h5000, 16'h12AB, 2'd0, 1'b0); mem_resp = 1'b0; settle();
    chk("stb_wdata", {16'd0, mem_wdata}, 32'hABAB);
    chk("stb_be",    {30'd0, mem_byte_enable}, 32'd1);
    chk("stb_wr",    {31'd0, mem_write}, 32'd1);
    chk("stb_rd",    {31'd0, mem_read}, 32'd0);
    chk("stb_stall", {31'd0, stall_out}, 32'd1);
    step(); mem_resp = 1'b1; settle();
    chk("stb_done",  {31'd0, stall_out}, 32'd0);
    chk("stb_lrf",   {31'd0, load_regfile_out}, 32'd0);

    // LDI: pointer 0x6000, then data 0x1234.
    step(); drive(1'b1, 3'd5, 16'h2000, 16'h0000, 2'd1, 1'b1);
    mem_rdata = 16'h6000; mem_resp = 1'b1; settle();
    chk("ldi_paddr", {16'd0, mem_address}, 32'h2000);
    chk("ldi_prd",   {31'd0, mem_read}, 32'd1);
    chk("ldi_pst",   {31'd0, stall_out}, 32'd1);
    chk("ldi_plrf",  {31'd0, load_regfile_out}, 32'd0);
    step(); mem_resp = 1'b0; mem_rdata = 16'h0000; settle();
    chk("ldi_gap_rd", {31'd0, mem_read}, 32'd0);
    chk("ldi_gap_st", {31'd0, stall_out}, 32'd1);
    step(); settle();
    chk("ldi_daddr", {16'd0, mem_address}, 32'h6000);
    chk("ldi_drd",   {31'd0, mem_read}, 32'd1);
    chk("ldi_dst",   {31'd0, stall_out}, 32'd1);
    chk("ldi_dlrf",  {31'd0, load_regfile_out}, 32'd0);
    step(); mem_rdata = 16'h1234; mem_resp = 1'b1; settle();
    chk("ldi_rfm",   {16'd0, regfilemux_out}, 32'h1234);
    chk("ldi_lrf",   {31'd0, load_regfile_out}, 32'd1);
    chk("ldi_st",    {31'd0, stall_out}, 32'd0);

    // ADD with stray response: no request, ALU result written back.
    step(); drive(1'b1, 3'd0, 16'h0007, 16'h0000, 2'd0, 1'b1); mem_resp = 1'b1; settle();
    chk("add_rd",   {31'd0, mem_read}, 32'd0);
    chk("add_wr",   {31'd0, mem_write}, 32'd0);
    chk("add_st",   {31'd0, stall_out}, 32'd0);
    chk("add_rfm",  {16'd0, regfilemux_out}, 32'h0007);
    chk("add_lrf",  {31'd0, load_regfile_out}, 32'd1);
    regfilemux_sel_in = 2'd2; pc_in = 16'h0102; settle();
    chk("jsr_rfm",  {16'd0, regfilemux_out}, 32'h0102);
    regfilemux_sel_in = 2'd3; settle();
    chk("sel3_rfm", {16'd0, regfilemux_out}, 32'h0007);
    mem_op_in = 3'd7; mem_resp = 1'b0; settle();
    chk("op7_rd",   {31'd0, mem_read}, 32'd0);
    chk("op7_st",   {31'd0, stall_out}, 32'd0);
    drive(1'b0, 3'd1, 16'h3000, 16'h0000, 2'd1, 1'b1); settle();
    chk("inv_rd",   {31'd0, mem_read}, 32'd0);
    chk("inv_lrf",  {31'd0, load_regfile_out}, 32'd0);

    // STI, reset asserted during the data write.
    step(); drive(1'b1, 3'd6, 16'h7000, 16'h5555, 2'd0, 1'b0);
    mem_rdata = 16'h8001; mem_resp = 1'b1; settle();
    chk("sti_prd", {31'd0, mem_read}, 32'd1);
    chk("sti_pbe", {30'd0, mem_byte_enable}, 32'd0);
    step(); mem_resp = 1'b0; settle();
    step(); settle();
    chk("sti_addr",  {16'd0, mem_address}, 32'h8000);
    chk("sti_wr",    {31'd0, mem_write}, 32'd1);
    chk("sti_wdata", {16'd0, mem_wdata}, 32'h5555);
    chk("sti_be",    {30'd0, mem_byte_enable}, 32'd3);
    rst = 1'b1; settle();
    chk("strst_wr",    {31'd0, mem_write}, 32'd0);
    chk("strst_addr",  {16'd0, mem_address}, 32'd0);
    chk("strst_stall", {31'd0, stall_out}, 32'd0);
    chk("strst_be",    {30'd0, mem_byte_enable}, 32'd0);
    step(); settle();
`ifdef MEM_STAGE_PERF_EN
    chk("strst_cnt", stall_count, 32'd0);
`endif
    // Late response after reset with nothing live.
    rst = 1'b0; valid_in = 1'b0; mem_resp = 1'b1; settle();
    chk("late_rd", {31'd0, mem_read}, 32'd0);
    chk("late_wr", {31'd0, mem_write}, 32'd0);
    chk("late_st", {31'd0, stall_out}, 32'd0);
    // Re-present the STI: IDLE means a pointer read at the ALU address.
    step(); valid_in = 1'b1; mem_resp = 1'b0; settle();
    chk("post_rd",   {31'd0, mem_read}, 32'd1);
    chk("post_wr",   {31'd0, mem_write}, 32'd0);
    chk("post_addr", {16'd0, mem_address}, 32'h7000);
    step(); settle();
`ifdef MEM_STAGE_PERF_EN
    chk("post_cnt", stall_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
